// File: rtl/car_pkg.sv
// car_pkg - shared constants, heading encoding and controller state type
// for the car motion controller and its edge-probe helper.
// Optional feature macro: CAR_WALL_PROBE_EN (adds the PROBE and WAIT states).
package car_pkg;

    // Default geometry of the car and the screen
    localparam int CAR_DEF_W    = 8;
    localparam int CAR_DEF_H    = 8;
    localparam int CAR_SCREEN_W = 160;
    localparam int CAR_SCREEN_H = 120;
    localparam int CAR_START_X  = 8;
    localparam int CAR_START_Y  = 56;

    // Map colour that counts as an obstacle
    localparam logic [8:0] CAR_WALL_COLOUR = 9'h000;

    // Heading encoding shared with the draw/erase engines
    localparam logic [2:0] DIR_UP    = 3'd0;
    localparam logic [2:0] DIR_RIGHT = 3'd1;
    localparam logic [2:0] DIR_DOWN  = 3'd2;
    localparam logic [2:0] DIR_LEFT  = 3'd3;

`ifdef CAR_WALL_PROBE_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_PROBE,
        S_WAIT,
        S_EDGE,
        S_COMMIT
    } car_state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_EDGE,
        S_COMMIT
    } car_state_t;
`endif

    // Linear map address of pixel (x, y); widened to 15 bits before the multiply-add
    function automatic logic [14:0] pixelAddr(input logic [7:0] x,
                                              input logic [6:0] y,
                                              input int         screenW);
        return 15'(y) * 15'(screenW) + 15'(x);
    endfunction

endpackage

// File: rtl/car_edge_probe.sv
// car_edge_probe - walks N map addresses along one edge of the car, one per
// cycle, and compares the returned colour one cycle later. hit is sticky for
// the duration of a probe and also includes the compare of the current cycle,
// so the caller can use it in the same cycle that done is high.
module car_edge_probe
    import car_pkg::*;
#(
    parameter int         SCREEN_W    = CAR_SCREEN_W,
    parameter logic [8:0] WALL_COLOUR = CAR_WALL_COLOUR
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [7:0]  x_i,
    input  logic [6:0]  y_i,
    input  logic        axis_i,
    input  logic [7:0]  count_i,
    input  logic [8:0]  wall_q_i,
    output logic [14:0] wall_addr_o,
    output logic        last_o,
    output logic        hit_o,
    output logic        done_o
);

    logic [14:0] addr_q;
    logic [7:0]  remain_q;
    logic        axis_q;
    logic        active_q;
    logic        cmpValid_q;
    logic        hit_q;
    logic        isWall;
    logic [14:0] stride;

    // Colour compare and per-step address increment (1 along a row, a full line down a column)
    always_comb begin
        isWall = (wall_q_i == WALL_COLOUR);
        stride = axis_q ? 15'(SCREEN_W) : 15'd1;
    end

    // Address sequencer with a one-cycle-lagged compare; abort drops the probe immediately
    always_ff @(posedge clock) begin
        if (!resetn || abort_i) begin
            addr_q     <= '0;
            remain_q   <= '0;
            axis_q     <= 1'b0;
            active_q   <= 1'b0;
            cmpValid_q <= 1'b0;
            hit_q      <= 1'b0;
        end else if (start_i) begin
            addr_q     <= pixelAddr(x_i, y_i, SCREEN_W);
            remain_q   <= count_i;
            axis_q     <= axis_i;
            active_q   <= (count_i != 8'd0);
            cmpValid_q <= 1'b0;
            hit_q      <= 1'b0;
        end else begin
            cmpValid_q <= active_q;
            if (cmpValid_q && isWall) begin
                hit_q <= 1'b1;
            end
            if (active_q) begin
                remain_q <= remain_q - 8'd1;
                if (remain_q == 8'd1) begin
                    active_q <= 1'b0;
                    addr_q   <= '0;
                end else begin
                    addr_q <= addr_q + stride;
                end
            end
        end
    end

    assign wall_addr_o = addr_q;
    assign last_o      = active_q && (remain_q == 8'd1);
    assign done_o      = cmpValid_q && !active_q;
    assign hit_o       = hit_q || (cmpValid_q && isWall);

endmodule

// File: rtl/car_motion_ctrl.sv
// car_motion_ctrl - once per frame tick picks a move from the direction keys,
// refuses it at the screen border (and, with CAR_WALL_PROBE_EN defined, when
// the leading edge touches a wall pixel in the map), then publishes the new
// position/heading with a one-cycle move_valid pulse.
// Optional feature macro: CAR_WALL_PROBE_EN.
module car_motion_ctrl
    import car_pkg::*;
#(
    parameter int         CAR_W       = CAR_DEF_W,
    parameter int         CAR_H       = CAR_DEF_H,
    parameter int         SCREEN_W    = CAR_SCREEN_W,
    parameter int         SCREEN_H    = CAR_SCREEN_H,
    parameter int         START_X     = CAR_START_X,
    parameter int         START_Y     = CAR_START_Y,
    parameter logic [8:0] WALL_COLOUR = CAR_WALL_COLOUR
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        frame_tick,
    input  logic        game_active,
    input  logic        respawn,
    input  logic        key_up,
    input  logic        key_down,
    input  logic        key_left,
    input  logic        key_right,
    output logic [14:0] wall_addr,
    input  logic [8:0]  wall_q,
    output logic [7:0]  nextX,
    output logic [6:0]  nextY,
    output logic [2:0]  dir,
    output logic        move_valid,
    output logic        blocked,
    output logic        busy
);

    car_state_t  state_q;
    logic [7:0]  nextX_q;
    logic [7:0]  nextX_d;
    logic [6:0]  nextY_q;
    logic [6:0]  nextY_d;
    logic [2:0]  dir_q;
    logic [2:0]  dirLatch_q;
    logic        moveValid_q;
    logic        blocked_q;
    logic        busy_q;
    logic        edgeBlk_q;

    logic        keyPressed;
    logic [2:0]  keyDir;
    logic        atLimit;
    logic        accept;
    logic        commitNow;
    logic        commitBlk;

    logic [7:0]  probeX;
    logic [6:0]  probeY;
    logic        probeAxis;
    logic [7:0]  probeCount;
    logic        probeStart;
    logic        probeLast;
    logic        probeHit;
    logic        probeDone;
    logic [14:0] probeAddr;

    // Key priority up > down > left > right, and whether that move would leave the screen
    always_comb begin
        keyPressed = key_up || key_down || key_left || key_right;
        keyDir     = DIR_RIGHT;
        if (key_up) begin
            keyDir = DIR_UP;
        end else if (key_down) begin
            keyDir = DIR_DOWN;
        end else if (key_left) begin
            keyDir = DIR_LEFT;
        end
        atLimit = 1'b0;
        case (keyDir)
            DIR_UP:    atLimit = (nextY_q == 7'd0);
            DIR_DOWN:  atLimit = ((int'(nextY_q) + CAR_H) == SCREEN_H);
            DIR_LEFT:  atLimit = (nextX_q == 8'd0);
            default:   atLimit = ((int'(nextX_q) + CAR_W) == SCREEN_W);
        endcase
    end

    // First pixel, walking axis and length of the leading edge for the chosen move
    always_comb begin
        probeX     = nextX_q;
        probeY     = nextY_q;
        probeAxis  = 1'b0;
        probeCount = 8'(CAR_W);
        case (keyDir)
            DIR_UP:   probeY = nextY_q - 7'd1;
            DIR_DOWN: probeY = nextY_q + 7'(CAR_H);
            DIR_LEFT: begin
                probeX     = nextX_q - 8'd1;
                probeAxis  = 1'b1;
                probeCount = 8'(CAR_H);
            end
            default: begin
                probeX     = nextX_q + 8'(CAR_W);
                probeAxis  = 1'b1;
                probeCount = 8'(CAR_H);
            end
        endcase
    end

    // One-pixel step in the latched direction, applied only if the move is not refused
    always_comb begin
        nextX_d = nextX_q;
        nextY_d = nextY_q;
        case (dirLatch_q)
            DIR_UP:    nextY_d = nextY_q - 7'd1;
            DIR_DOWN:  nextY_d = nextY_q + 7'd1;
            DIR_LEFT:  nextX_d = nextX_q - 8'd1;
            default:   nextX_d = nextX_q + 8'd1;
        endcase
    end

    // Tick acceptance (respawn drops a coincident tick) and when/how a move is committed
    always_comb begin
        accept = (state_q == S_IDLE) && frame_tick && game_active && keyPressed && !respawn;
`ifdef CAR_WALL_PROBE_EN
        probeStart = accept && !atLimit;
        commitNow  = (state_q == S_EDGE) || ((state_q == S_WAIT) && probeDone);
        commitBlk  = (state_q == S_EDGE) ? edgeBlk_q : probeHit;
`else
        probeStart = 1'b0;
        commitNow  = (state_q == S_EDGE);
        commitBlk  = edgeBlk_q;
`endif
    end

    car_edge_probe #(
        .SCREEN_W    (SCREEN_W),
        .WALL_COLOUR (WALL_COLOUR)
    ) u_probe (
        .clock       (clock),
        .resetn      (resetn),
        .start_i     (probeStart),
        .abort_i     (respawn),
        .x_i         (probeX),
        .y_i         (probeY),
        .axis_i      (probeAxis),
        .count_i     (probeCount),
        .wall_q_i    (wall_q),
        .wall_addr_o (probeAddr),
        .last_o      (probeLast),
        .hit_o       (probeHit),
        .done_o      (probeDone)
    );

    // Move controller: respawn overrides everything, commit publishes, otherwise advance the state
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            nextX_q     <= 8'(START_X);
            nextY_q     <= 7'(START_Y);
            dir_q       <= DIR_UP;
            dirLatch_q  <= DIR_UP;
            moveValid_q <= 1'b0;
            blocked_q   <= 1'b0;
            busy_q      <= 1'b0;
            edgeBlk_q   <= 1'b0;
        end else if (respawn) begin
            state_q     <= S_COMMIT;
            nextX_q     <= 8'(START_X);
            nextY_q     <= 7'(START_Y);
            dir_q       <= DIR_UP;
            moveValid_q <= 1'b1;
            blocked_q   <= 1'b0;
            busy_q      <= 1'b1;
        end else if (commitNow) begin
            state_q     <= S_COMMIT;
            dir_q       <= dirLatch_q;
            moveValid_q <= 1'b1;
            blocked_q   <= commitBlk;
            if (!commitBlk) begin
                nextX_q <= nextX_d;
                nextY_q <= nextY_d;
            end
        end else begin
            moveValid_q <= 1'b0;
            blocked_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        dirLatch_q <= keyDir;
                        edgeBlk_q  <= atLimit;
                        busy_q     <= 1'b1;
`ifdef CAR_WALL_PROBE_EN
                        state_q    <= atLimit ? S_EDGE : S_PROBE;
`else
                        state_q    <= S_EDGE;
`endif
                    end
                end
`ifdef CAR_WALL_PROBE_EN
                S_PROBE: begin
                    if (probeLast) begin
                        state_q <= S_WAIT;
                    end
                end
`endif
                S_COMMIT: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef CAR_WALL_PROBE_EN
    assign wall_addr = probeAddr;
`else
    logic unusedProbe;
    assign wall_addr   = '0;
    assign unusedProbe = ^{probeAddr, probeLast, probeHit, probeDone};
`endif

    assign nextX      = nextX_q;
    assign nextY      = nextY_q;
    assign dir        = dir_q;
    assign move_valid = moveValid_q;
    assign blocked    = blocked_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_car_motion_ctrl.sv
// tb_car_motion_ctrl - directed stimulus for car_motion_ctrl with a cycle-level
// model of moves (position, heading, pulse timing, probe addresses) checked
// every cycle, plus hand-computed expectations for the headline scenarios.
// Honours CAR_WALL_PROBE_EN the same way the design does.
module tb_car_motion_ctrl;

    localparam int SW = 160;
    localparam int SH = 120;
    localparam int CW = 8;
    localparam int CH = 8;
`ifdef CAR_WALL_PROBE_EN
    localparam bit PROBE_EN = 1'b1;
    localparam int LAT_MOVE = 10;
`else
    localparam bit PROBE_EN = 1'b0;
    localparam int LAT_MOVE = 2;
`endif

    logic        clock       = 1'b0;
    logic        resetn      = 1'b0;
    logic        frame_tick  = 1'b0;
    logic        game_active = 1'b0;
    logic        respawn     = 1'b0;
    logic        key_up      = 1'b0;
    logic        key_down    = 1'b0;
    logic        key_left    = 1'b0;
    logic        key_right   = 1'b0;
    logic [14:0] wall_addr;
    logic [8:0]  wall_q      = 9'h1FF;
    logic [7:0]  nextX;
    logic [6:0]  nextY;
    logic [2:0]  dir;
    logic        move_valid;
    logic        blocked;
    logic        busy;

    logic [8:0]  mapMem [0:SW*SH-1];

    int errors   = 0;
    int checks   = 0;
    int pulseCnt = 0;
    bit checkOn  = 1'b0;

    // Model state
    int mX = 8;
    int mY = 56;
    int mDir = 0;
    int mPend = 0;
    int mPendDir = 0;
    bit mPendBlk = 1'b0;
    bit mValid = 1'b0;
    bit mBlocked = 1'b0;
    bit mBusy = 1'b0;
    int mAddr = 0;
    int addrQ[$];

    always #5 clock = ~clock;

    car_motion_ctrl dut (
        .clock       (clock),
        .resetn      (resetn),
        .frame_tick  (frame_tick),
        .game_active (game_active),
        .respawn     (respawn),
        .key_up      (key_up),
        .key_down    (key_down),
        .key_left    (key_left),
        .key_right   (key_right),
        .wall_addr   (wall_addr),
        .wall_q      (wall_q),
        .nextX       (nextX),
        .nextY       (nextY),
        .dir         (dir),
        .move_valid  (move_valid),
        .blocked     (blocked),
        .busy        (busy)
    );

    // Map memory with one cycle of read latency
    always @(posedge clock) begin
        if (int'(wall_addr) < SW*SH) wall_q <= mapMem[wall_addr];
        else                         wall_q <= 9'h1FF;
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Behavioural model: a move accepted at a tick completes lat cycles later
    always @(posedge clock) begin : modelStep
        bit prevBusy;
        int d;
        bit lim;
        int px;
        int py;
        if (!resetn) begin
            mX = 8; mY = 56; mDir = 0; mPend = 0;
            mValid = 0; mBlocked = 0; mBusy = 0; mAddr = 0;
            addrQ.delete();
        end else if (respawn) begin
            mX = 8; mY = 56; mDir = 0; mPend = 0;
            mValid = 1; mBlocked = 0; mBusy = 1; mAddr = 0;
            addrQ.delete();
        end else begin
            prevBusy = mBusy;
            mValid   = 0;
            mBlocked = 0;
            if (addrQ.size() > 0) mAddr = addrQ.pop_front();
            else                  mAddr = 0;
            if (mPend > 0) begin
                mPend--;
                if (mPend == 0) begin
                    mDir     = mPendDir;
                    mValid   = 1;
                    mBlocked = mPendBlk;
                    if (!mPendBlk) begin
                        if (mPendDir == 0)      mY = mY - 1;
                        else if (mPendDir == 1) mX = mX + 1;
                        else if (mPendDir == 2) mY = mY + 1;
                        else                    mX = mX - 1;
                    end
                end
            end else if (!prevBusy && frame_tick && game_active &&
                         (key_up || key_down || key_left || key_right)) begin
                d = key_up ? 0 : key_down ? 2 : key_left ? 3 : 1;
                lim = (d == 0 && mY == 0) || (d == 2 && mY + CH == SH) ||
                      (d == 3 && mX == 0) || (d == 1 && mX + CW == SW);
                mPendDir = d;
                mPendBlk = lim;
                mPend    = 1;
                if (!lim && PROBE_EN) begin
                    mPendBlk = 0;
                    for (int i = 0; i < ((d == 0 || d == 2) ? CW : CH); i++) begin
                        case (d)
                            0:       begin px = mX + i;  py = mY - 1;  end
                            2:       begin px = mX + i;  py = mY + CH; end
                            3:       begin px = mX - 1;  py = mY + i;  end
                            default: begin px = mX + CW; py = mY + i;  end
                        endcase
                        addrQ.push_back(py * SW + px);
                        if (mapMem[py * SW + px] == 9'h000) mPendBlk = 1;
                    end
                    mPend = addrQ.size() + 1;
                    mAddr = addrQ.pop_front();
                end
            end
            mBusy = (mPend > 0) || mValid;
        end
    end

    // Compare DUT with the model every cycle, just after the active edge
    always @(posedge clock) begin
        #1;
        if (checkOn) begin
            checkOutput("move_valid", move_valid, mValid);
            checkOutput("blocked",    blocked,    mBlocked);
            checkOutput("busy",       busy,       mBusy);
            checkOutput("nextX",      nextX,      mX);
            checkOutput("nextY",      nextY,      mY);
            checkOutput("dir",        dir,        mDir);
            checkOutput("wall_addr",  wall_addr,  mAddr);
            if (move_valid === 1'b1) pulseCnt++;
        end
    end

    task automatic applyStimulus(input logic tick, input logic up, input logic down,
                                 input logic left, input logic right,
                                 input logic resp, input logic act);
        @(negedge clock);
        frame_tick  = tick;
        key_up      = up;
        key_down    = down;
        key_left    = left;
        key_right   = right;
        respawn     = resp;
        game_active = act;
    endtask

    // Count edges until move_valid appears (bounded), then let the pulse cycle pass
    task automatic waitMove(output int lat);
        lat = 0;
        do begin
            @(posedge clock);
            #1;
            lat++;
            frame_tick = 0;
            respawn    = 0;
            key_up     = 0;
            key_down   = 0;
            key_left   = 0;
            key_right  = 0;
        end while (move_valid !== 1'b1 && lat < 40);
        checkOutput("move_valid seen", move_valid, 1'b1);
        @(negedge clock);
    endtask

    initial begin : stimulus
        int lat;
        int startCnt;
        for (int i = 0; i < SW*SH; i++) mapMem[i] = 9'h1FF;

        // Reset
        resetn = 0;
        repeat (2) @(posedge clock);
        #1;
        checkOn = 1;
        checkOutput("reset nextX", nextX, 8);
        checkOutput("reset nextY", nextY, 56);
        checkOutput("reset dir", dir, 0);
        checkOutput("reset move_valid", move_valid, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset wall_addr", wall_addr, 0);
        @(negedge clock);
        resetn = 1;

        // Right on an open map
        applyStimulus(1, 0, 0, 0, 1, 0, 1);
        waitMove(lat);
        checkOutput("right latency", lat, LAT_MOVE);
        checkOutput("right nextX", nextX, 9);
        checkOutput("right nextY", nextY, 56);
        checkOutput("right dir", dir, 1);
        checkOutput("right blocked", blocked, 0);

        // Respawn from idle
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        waitMove(lat);
        checkOutput("respawn latency", lat, 1);
        checkOutput("respawn nextX", nextX, 8);

        // Up and left together: up wins
        applyStimulus(1, 1, 0, 1, 0, 0, 1);
        waitMove(lat);
        checkOutput("up latency", lat, LAT_MOVE);
        checkOutput("up nextX", nextX, 8);
        checkOutput("up nextY", nextY, 55);
        checkOutput("up dir", dir, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        waitMove(lat);

        // Wall pixel on the right leading edge
        mapMem[60*SW + 16] = 9'h000;
        applyStimulus(1, 0, 0, 0, 1, 0, 1);
        waitMove(lat);
        checkOutput("wall blocked", blocked, PROBE_EN ? 1 : 0);
        checkOutput("wall nextX", nextX, PROBE_EN ? 8 : 9);
        checkOutput("wall dir", dir, 1);
        mapMem[60*SW + 16] = 9'h1FF;
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        waitMove(lat);

        // Drive to the right border, then try to go past it
        for (int i = 0; i < 144; i++) begin
            applyStimulus(1, 0, 0, 0, 1, 0, 1);
            waitMove(lat);
        end
        checkOutput("border approach nextX", nextX, 152);
        applyStimulus(1, 0, 0, 0, 1, 0, 1);
        waitMove(lat);
        checkOutput("border latency", lat, 2);
        checkOutput("border blocked", blocked, 1);
        checkOutput("border nextX", nextX, 152);
        checkOutput("border dir", dir, 1);

        // Respawn three cycles into a move, with a coincident tick
        applyStimulus(1, 0, 1, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 1, 1, 1);
        waitMove(lat);
        checkOutput("abort latency", lat, 1);
        checkOutput("abort nextX", nextX, 8);
        checkOutput("abort nextY", nextY, 56);
        checkOutput("abort dir", dir, 0);
        checkOutput("abort blocked", blocked, 0);
        startCnt = pulseCnt;
        repeat (12) applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("dropped tick pulses", pulseCnt - startCnt, 0);

        // Ticks while busy are ignored
        startCnt = pulseCnt;
        applyStimulus(1, 0, 0, 0, 1, 0, 1);
        applyStimulus(1, 0, 0, 0, 1, 0, 1);
        applyStimulus(1, 0, 0, 0, 1, 0, 1);
        repeat (14) applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("busy tick pulses", pulseCnt - startCnt, 1);
        checkOutput("busy tick nextX", nextX, 9);

        // Tick with game inactive
        startCnt = pulseCnt;
        applyStimulus(1, 0, 0, 0, 1, 0, 0);
        repeat (12) applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("inactive pulses", pulseCnt - startCnt, 0);
        checkOutput("inactive nextX", nextX, 9);
        checkOutput("inactive busy", busy, 0);

        // game_active falls right after the tick: the move still completes
        applyStimulus(1, 0, 0, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        waitMove(lat);
        checkOutput("late inactive latency", lat, LAT_MOVE - 1);
        checkOutput("late inactive nextX", nextX, 8);
        checkOutput("late inactive dir", dir, 3);
        checkOutput("late inactive blocked", blocked, 0);

        repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOn = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
